// File: rtl/if_fetch_unit_if.sv
// Signal bundle around the fetch stage: redirect from the branch/jump logic,
// the InstMem request/response channel, and the valid/ready hand-off to ID.
// master = fetch unit, slave = the surrounding pipeline and instruction memory.
interface if_fetch_unit_if #(
    parameter int PC_WIDTH   = 32,
    parameter int INST_WIDTH = 32
);
    logic                  redirect_valid;
    logic [PC_WIDTH-1:0]   redirect_addr;

    logic                  rom_ce;
    logic [PC_WIDTH-1:0]   rom_addr;
    logic                  rom_valid;
    logic [INST_WIDTH-1:0] rom_data;

    logic                  inst_valid;
    logic [INST_WIDTH-1:0] inst;
    logic [PC_WIDTH-1:0]   inst_pc;
    logic                  id_ready;

    modport master (
        input  redirect_valid, redirect_addr,
        output rom_ce, rom_addr,
        input  rom_valid, rom_data,
        output inst_valid, inst, inst_pc,
        input  id_ready
    );

    modport slave (
        output redirect_valid, redirect_addr,
        input  rom_ce, rom_addr,
        output rom_valid, rom_data,
        input  inst_valid, inst, inst_pc,
        output id_ready
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one InstMem request at a
// time, buffers responses with their PCs in a small prefetch FIFO and hands
// the FIFO head to ID. A redirect flushes the FIFO and drains any request
// that was already in flight so its data never reaches ID.
module if_fetch_unit #(
    parameter int                  PC_WIDTH   = 32,
    parameter int                  INST_WIDTH = 32,
    parameter int                  PC_STEP    = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
    parameter int                  FIFO_DEPTH = 2
) (
    input logic             clk,
    input logic             rst,
    if_fetch_unit_if.master bus
);
    localparam int                  PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]      DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]      CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0]    PTR_ONE = PTR_W'(1);
    localparam logic [PC_WIDTH-1:0] STEP_C  = PC_WIDTH'(PC_STEP);

    // IDLE: nothing in flight. WAIT: live request in flight.
    // DRAIN: request in flight whose response must be thrown away.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state;
    logic [PC_WIDTH-1:0]   fetch_pc;
    logic [INST_WIDTH-1:0] fifo_inst [FIFO_DEPTH];
    logic [PC_WIDTH-1:0]   fifo_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count;

    logic outstanding;
    logic head_valid;
    logic push;
    logic pop;
    logic issue;

    assign outstanding = (state != IDLE);
    assign head_valid  = (count != '0);
    assign pop         = head_valid && bus.id_ready;
    // Only a live response is stored; one that coincides with a redirect is stale.
    assign push        = (state == WAIT) && bus.rom_valid && !bus.redirect_valid;
    // The in-flight request is counted so its response always has a free slot.
    assign issue       = (state == IDLE) && !bus.redirect_valid &&
                         ((count + {{PTR_W{1'b0}}, outstanding}) < DEPTH_C);

    // Fetch FSM, registered request outputs and FIFO bookkeeping.
    // NOTE: every register here uses <= so all of them update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            fetch_pc     <= RESET_PC;
            bus.rom_ce   <= 1'b0;
            bus.rom_addr <= '0;
            count        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc   <= bus.redirect_addr;
            bus.rom_ce <= 1'b0;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            // A request still in flight must be drained; one answered this
            // very cycle is simply dropped.
            if (outstanding && !bus.rom_valid) begin
                state <= DRAIN;
            end else begin
                state <= IDLE;
            end
        end else begin
            bus.rom_ce <= issue;
            if (issue) begin
                bus.rom_addr <= fetch_pc;
                fetch_pc     <= fetch_pc + STEP_C;
                state        <= WAIT;
            end else if (outstanding && bus.rom_valid) begin
                state <= IDLE;
            end

            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end

    // Prefetch storage; rom_addr still holds the address of the request being answered.
    // NOTE: the storage array is not reset; the outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst[wr_ptr] <= bus.rom_data;
            fifo_pc[wr_ptr]   <= bus.rom_addr;
        end
    end

    assign bus.inst_valid = head_valid;
    assign bus.inst       = head_valid ? fifo_inst[rd_ptr] : '0;
    assign bus.inst_pc    = head_valid ? fifo_pc[rd_ptr]   : '0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit. The main instance (FIFO_DEPTH=2, RESET_PC=0)
// is served by a fixed-latency InstMem model; a second instance (FIFO_DEPTH=4,
// RESET_PC=0x40) is driven by hand for the mid-stream reset scenario.
`timescale 1ns/1ps
module tb_if_fetch_unit;
    localparam logic [31:0] KEY = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_fetch_unit_if #(.PC_WIDTH(32), .INST_WIDTH(32)) bus ();
    if_fetch_unit_if #(.PC_WIDTH(32), .INST_WIDTH(32)) bus4 ();

    if_fetch_unit #(
        .PC_WIDTH(32), .INST_WIDTH(32), .PC_STEP(4), .RESET_PC(32'h0), .FIFO_DEPTH(2)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    if_fetch_unit #(
        .PC_WIDTH(32), .INST_WIDTH(32), .PC_STEP(4), .RESET_PC(32'h40), .FIFO_DEPTH(4)
    ) dut4 (
        .clk(clk), .rst(rst), .bus(bus4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int          lat       = 1;
    logic        pend      = 1'b0;
    int          cnt       = 0;
    logic [31:0] pend_addr = '0;

    logic [31:0] got_pc[$];
    logic [31:0] got_inst[$];

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return a ^ KEY;
    endfunction

    // InstMem model for the main instance: answers each request so that
    // rom_valid is sampled 'lat' rising edges after the one that raised rom_ce.
    always @(negedge clk) begin
        bus.rom_valid = 1'b0;
        if (bus.rom_ce === 1'b1) begin
            pend      = 1'b1;
            pend_addr = bus.rom_addr;
            cnt       = lat;
        end
        if (pend) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
                bus.rom_valid = 1'b1;
                bus.rom_data  = rom_word(pend_addr);
                pend          = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, n_checks=%0d expected completion", n_checks);
        $fatal(1, "simulation did not complete");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 50 && pend; i++) tick();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_req(output logic found, output int waited);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (bus.rom_ce !== 1'b1 && waited < 40);
        found = (bus.rom_ce === 1'b1);
    endtask

    task automatic wait_req4(output logic found);
        int waited;
        waited = 0;
        do begin
            tick();
            waited++;
        end while (bus4.rom_ce !== 1'b1 && waited < 40);
        found = (bus4.rom_ce === 1'b1);
    endtask

    task automatic collect(input int n);
        got_pc.delete();
        got_inst.delete();
        for (int k = 0; k < 40; k++) begin
            if (bus.inst_valid === 1'b1 && bus.id_ready === 1'b1) begin
                got_pc.push_back(bus.inst_pc);
                got_inst.push_back(bus.inst);
            end
            if (got_pc.size() >= n) break;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.id_ready = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus.rom_ce !== 1'b0) begin
            n_fail++; $display("FAIL reset_rom_ce: got %b expected 0", bus.rom_ce);
        end
        n_checks++;
        if (bus.rom_addr !== 32'h0) begin
            n_fail++; $display("FAIL reset_rom_addr: got %h expected 00000000", bus.rom_addr);
        end
        n_checks++;
        if (bus.inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_inst_valid: got %b expected 0", bus.inst_valid);
        end
        n_checks++;
        if (bus.inst !== 32'h0) begin
            n_fail++; $display("FAIL reset_inst: got %h expected 00000000", bus.inst);
        end
        n_checks++;
        if (bus.inst_pc !== 32'h0) begin
            n_fail++; $display("FAIL reset_inst_pc: got %h expected 00000000", bus.inst_pc);
        end
    endtask

    task automatic test_stream();
        logic [31:0] a;
        lat = 1;
        bus.id_ready = 1'b1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 32'(i * 4);
            tick();
            n_checks++;
            if (bus.rom_ce !== 1'b1 || bus.rom_addr !== a || bus.inst_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stream_req[%0d]: rom_ce=%b rom_addr=%h inst_valid=%b, expected 1 %h 0",
                         i, bus.rom_ce, bus.rom_addr, bus.inst_valid, a);
            end
            tick();
            n_checks++;
            if (bus.rom_ce !== 1'b0 || bus.inst_valid !== 1'b1 || bus.inst_pc !== a ||
                bus.inst !== rom_word(a)) begin
                n_fail++;
                $display("FAIL stream_inst[%0d]: rom_ce=%b valid=%b pc=%h inst=%h, expected 0 1 %h %h",
                         i, bus.rom_ce, bus.inst_valid, bus.inst_pc, bus.inst, a, rom_word(a));
            end
        end
    endtask

    task automatic test_backpressure();
        int          reqs;
        int          held_bad;
        logic [31:0] req_addr [2];
        logic [31:0] exp;
        lat = 1;
        bus.id_ready = 1'b0;
        do_reset();
        reqs     = 0;
        held_bad = 0;
        req_addr[0] = 'x;
        req_addr[1] = 'x;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.rom_ce === 1'b1) begin
                if (reqs < 2) req_addr[reqs] = bus.rom_addr;
                reqs++;
            end
            if (bus.inst_valid === 1'b1 && bus.inst_pc !== 32'h0) held_bad++;
        end
        n_checks++;
        if (reqs != 2) begin
            n_fail++; $display("FAIL bp_req_count: got %0d requests expected 2", reqs);
        end
        n_checks++;
        if (req_addr[0] !== 32'h0 || req_addr[1] !== 32'h4) begin
            n_fail++;
            $display("FAIL bp_req_addr: got %h,%h expected 00000000,00000004", req_addr[0], req_addr[1]);
        end
        n_checks++;
        if (held_bad != 0) begin
            n_fail++; $display("FAIL bp_head_held: head changed %0d times, expected 0", held_bad);
        end
        n_checks++;
        if (bus.rom_ce !== 1'b0 || bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL bp_full_state: rom_ce=%b valid=%b pc=%h expected 0 1 00000000",
                     bus.rom_ce, bus.inst_valid, bus.inst_pc);
        end
        bus.id_ready = 1'b1;
        collect(3);
        for (int i = 0; i < 3; i++) begin
            exp = 32'(i * 4);
            n_checks++;
            if (got_pc.size() <= i) begin
                n_fail++; $display("FAIL bp_order[%0d]: nothing delivered, expected pc=%h", i, exp);
            end else if (got_pc[i] !== exp || got_inst[i] !== rom_word(exp)) begin
                n_fail++;
                $display("FAIL bp_order[%0d]: pc=%h inst=%h expected %h %h",
                         i, got_pc[i], got_inst[i], exp, rom_word(exp));
            end
        end
    endtask

    task automatic test_redirect_drain();
        logic found;
        int   waited;
        lat = 3;
        bus.id_ready = 1'b0;
        do_reset();
        wait_req(found, waited);
        n_checks++;
        if (!found || bus.rom_addr !== 32'h0) begin
            n_fail++; $display("FAIL rd_req0: found=%b addr=%h expected 1 00000000", found, bus.rom_addr);
        end
        wait_req(found, waited);
        n_checks++;
        if (!found || bus.rom_addr !== 32'h4) begin
            n_fail++; $display("FAIL rd_req4: found=%b addr=%h expected 1 00000004", found, bus.rom_addr);
        end
        repeat (4) tick();
        bus.id_ready = 1'b1;
        tick();
        bus.id_ready = 1'b0;
        n_checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h4) begin
            n_fail++; $display("FAIL rd_head4: valid=%b pc=%h expected 1 00000004", bus.inst_valid, bus.inst_pc);
        end
        wait_req(found, waited);
        n_checks++;
        if (!found || bus.rom_addr !== 32'h8) begin
            n_fail++; $display("FAIL rd_req8: found=%b addr=%h expected 1 00000008", found, bus.rom_addr);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 32'h100;
        tick();
        bus.redirect_valid = 1'b0;
        n_checks++;
        if (bus.inst_valid !== 1'b0 || bus.rom_ce !== 1'b0) begin
            n_fail++; $display("FAIL rd_flush: valid=%b rom_ce=%b expected 0 0", bus.inst_valid, bus.rom_ce);
        end
        wait_req(found, waited);
        n_checks++;
        if (!found || bus.rom_addr !== 32'h100 || waited != 3) begin
            n_fail++;
            $display("FAIL rd_req100: found=%b addr=%h after %0d cycles, expected 1 00000100 after 3",
                     found, bus.rom_addr, waited);
        end
        bus.id_ready = 1'b1;
        collect(1);
        n_checks++;
        if (got_pc.size() < 1) begin
            n_fail++; $display("FAIL rd_first: nothing delivered, expected pc=00000100");
        end else if (got_pc[0] !== 32'h100 || got_inst[0] !== rom_word(32'h100)) begin
            n_fail++;
            $display("FAIL rd_first: pc=%h inst=%h expected 00000100 %h", got_pc[0], got_inst[0], rom_word(32'h100));
        end
    endtask

    task automatic test_redirect_same_cycle();
        logic found;
        int   waited;
        lat = 2;
        bus.id_ready = 1'b1;
        do_reset();
        wait_req(found, waited);
        n_checks++;
        if (!found || bus.rom_addr !== 32'h0) begin
            n_fail++; $display("FAIL sc_req0: found=%b addr=%h expected 1 00000000", found, bus.rom_addr);
        end
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 32'h200;
        tick();
        bus.redirect_valid = 1'b0;
        n_checks++;
        if (bus.inst_valid !== 1'b0 || bus.rom_ce !== 1'b0) begin
            n_fail++; $display("FAIL sc_dropped: valid=%b rom_ce=%b expected 0 0", bus.inst_valid, bus.rom_ce);
        end
        tick();
        n_checks++;
        if (bus.rom_ce !== 1'b1 || bus.rom_addr !== 32'h200) begin
            n_fail++; $display("FAIL sc_req200: rom_ce=%b addr=%h expected 1 00000200", bus.rom_ce, bus.rom_addr);
        end
        collect(1);
        n_checks++;
        if (got_pc.size() < 1) begin
            n_fail++; $display("FAIL sc_first: nothing delivered, expected pc=00000200");
        end else if (got_pc[0] !== 32'h200 || got_inst[0] !== rom_word(32'h200)) begin
            n_fail++;
            $display("FAIL sc_first: pc=%h inst=%h expected 00000200 %h", got_pc[0], got_inst[0], rom_word(32'h200));
        end
    endtask

    task automatic test_wrap();
        logic found;
        int   waited;
        lat = 1;
        bus.id_ready = 1'b1;
        do_reset();
        wait_req(found, waited);
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 32'hFFFF_FFFC;
        tick();
        bus.redirect_valid = 1'b0;
        collect(2);
        n_checks++;
        if (got_pc.size() < 1 || got_pc[0] !== 32'hFFFF_FFFC || got_inst[0] !== rom_word(32'hFFFF_FFFC)) begin
            n_fail++;
            $display("FAIL wrap_top: %0d delivered, first pc=%h expected fffffffc",
                     got_pc.size(), (got_pc.size() > 0) ? got_pc[0] : 32'h0);
        end
        n_checks++;
        if (got_pc.size() < 2 || got_pc[1] !== 32'h0 || got_inst[1] !== rom_word(32'h0)) begin
            n_fail++;
            $display("FAIL wrap_zero: %0d delivered, second pc=%h expected 00000000",
                     got_pc.size(), (got_pc.size() > 1) ? got_pc[1] : 32'hx);
        end
    endtask

    task automatic test_reset_midstream();
        logic        found;
        logic [31:0] a;
        bus4.id_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            a = 32'h40 + 32'(i * 4);
            wait_req4(found);
            n_checks++;
            if (!found || bus4.rom_addr !== a) begin
                n_fail++; $display("FAIL mr_req[%0d]: found=%b addr=%h expected 1 %h", i, found, bus4.rom_addr, a);
            end
            bus4.rom_valid = 1'b1;
            bus4.rom_data  = rom_word(a);
            tick();
            bus4.rom_valid = 1'b0;
        end
        wait_req4(found);
        n_checks++;
        if (!found || bus4.rom_addr !== 32'h48 || bus4.inst_valid !== 1'b1 || bus4.inst_pc !== 32'h40) begin
            n_fail++;
            $display("FAIL mr_loaded: found=%b addr=%h valid=%b pc=%h expected 1 00000048 1 00000040",
                     found, bus4.rom_addr, bus4.inst_valid, bus4.inst_pc);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (bus4.rom_ce !== 1'b0 || bus4.rom_addr !== 32'h0 || bus4.inst_valid !== 1'b0 ||
            bus4.inst !== 32'h0 || bus4.inst_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL mr_cleared: ce=%b addr=%h valid=%b inst=%h pc=%h expected all zero",
                     bus4.rom_ce, bus4.rom_addr, bus4.inst_valid, bus4.inst, bus4.inst_pc);
        end
        rst = 1'b0;
        bus4.rom_valid = 1'b1;
        bus4.rom_data  = rom_word(32'h48);
        tick();
        n_checks++;
        if (bus4.rom_ce !== 1'b1 || bus4.rom_addr !== 32'h40 || bus4.inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mr_restart: ce=%b addr=%h valid=%b expected 1 00000040 0",
                     bus4.rom_ce, bus4.rom_addr, bus4.inst_valid);
        end
        bus4.rom_valid = 1'b1;
        bus4.rom_data  = rom_word(32'h40);
        tick();
        bus4.rom_valid = 1'b0;
        n_checks++;
        if (bus4.inst_valid !== 1'b1 || bus4.inst_pc !== 32'h40 || bus4.inst !== rom_word(32'h40)) begin
            n_fail++;
            $display("FAIL mr_first: valid=%b pc=%h inst=%h expected 1 00000040 %h",
                     bus4.inst_valid, bus4.inst_pc, bus4.inst, rom_word(32'h40));
        end
    endtask

    initial begin
        bus.redirect_valid  = 1'b0;
        bus.redirect_addr   = '0;
        bus.id_ready        = 1'b1;
        bus4.redirect_valid = 1'b0;
        bus4.redirect_addr  = '0;
        bus4.rom_valid      = 1'b0;
        bus4.rom_data       = '0;
        bus4.id_ready       = 1'b0;

        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drain();
        test_redirect_same_cycle();
        test_wrap();
        test_reset_midstream();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
